i2c_write_scheduler: RTL and testbench

Clocked I2C write-transaction master shared between two requesters. Round-robin arbitration picks one request and latches its 7-bit address and 8-bit data. The block then drives START, the address byte (R/W=0), ACK, the data byte, ACK and STOP onto open-drain SCL/SDA. It feeds the bus that the team's start/sequence-detecting FSMs monitor, and owns the only drivers on that bus.

---
 rtl/i2c_sched_pkg.sv | 43 ++++
 rtl/i2c_write_scheduler_quarter_tick.sv | 35 +++
 rtl/i2c_write_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_i2c_write_scheduler.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_sched_pkg.sv
// Shared types and constants for the I2C write scheduler: FSM state encoding,
// transaction lengths in quarter periods, and the SCL/SDA drive decode.
package i2c_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_ADDR  = 3'd2,
    ST_ACK1  = 3'd3,
    ST_DATA  = 3'd4,
    ST_ACK2  = 3'd5,
    ST_STOP  = 3'd6,
    ST_DONE  = 3'd7
  } state_e;

  localparam int SLOT_QUARTERS = 4;
  localparam int FULL_QUARTERS = 80;
  localparam int NACK_QUARTERS = 44;

  // Returns {scl_oe, sda_oe} for a state, quarter index and current data bit.
  function automatic logic [1:0] bus_drive(input state_e st, input logic [1:0] quarter,
                                           input logic data_bit);
    logic [1:0] drv;
    drv = 2'b00;
    case (st)
      ST_START:         drv = {1'b0, quarter[1]};
      ST_ADDR, ST_DATA: drv = {~quarter[1], ~data_bit};
      ST_ACK1, ST_ACK2: drv = {~quarter[1], 1'b0};
      ST_STOP: begin
        if (quarter == 2'd0) begin
          drv = 2'b11;
        end else if (quarter == 2'd1) begin
          drv = 2'b01;
        end else begin
          drv = 2'b00;
        end
      end
      default:          drv = 2'b00;
    endcase
    return drv;
  endfunction

endpackage

// File: rtl/i2c_write_scheduler_quarter_tick.sv
// Quarter-period tick generator: one-cycle pulse every CLK_DIV clocks, with the
// phase restarted by the grant pulse so quarter 0 begins the cycle after grant.
module i2c_quarter_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    if (restart || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/i2c_write_scheduler.sv
// Two-requester I2C write master: round-robin arbitration, then START, address
// byte, ACK, data byte, ACK and STOP on open-drain SCL/SDA.
module i2c_write_scheduler
  import i2c_sched_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [6:0] addr0,
  input  logic [6:0] addr1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic       sda_i,
  output logic [1:0] grant,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic       scl_oe,
  output logic       sda_oe
);

  state_e     state_q, state_d;
  logic [1:0] quarter_q, quarter_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       rr_q, rr_d;
  logic [1:0] grant_q, grant_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       nack_q, nack_d;
  logic       scl_oe_q, scl_oe_d;
  logic       sda_oe_q, sda_oe_d;
  logic       tick, restart, arb_en, slot_end;

  assign restart = |grant_q;

  i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    state_d   = state_q;
    quarter_d = quarter_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    data_d    = data_q;
    rr_d      = rr_q;
    grant_d   = 2'b00;
    busy_d    = busy_q;
    nack_d    = nack_q;
    // DONE counts as IDLE for arbitration so a waiting request is granted the next cycle.
    arb_en    = ((state_q == ST_IDLE) && (grant_q == 2'b00)) || (state_q == ST_DONE);
    slot_end  = tick && (quarter_q == 2'd3);

    case (state_q)
      ST_IDLE: begin
        if (grant_q != 2'b00) begin
          state_d   = ST_START;
          quarter_d = 2'd0;
          bit_d     = 3'd7;
          nack_d    = 1'b0;
          if (grant_q[0]) begin
            shift_d = {addr0, 1'b0};
            data_d  = data0;
          end else begin
            shift_d = {addr1, 1'b0};
            data_d  = data1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        if (tick) begin
          quarter_d = quarter_q + 2'd1;
        end else begin
          quarter_d = quarter_q;
        end
        if (tick && (quarter_q == 2'd2) && ((state_q == ST_ACK1) || (state_q == ST_ACK2))) begin
          nack_d = nack_q | sda_i;
        end else begin
          nack_d = nack_q;
        end
        if (slot_end) begin
          case (state_q)
            ST_START: begin
              state_d = ST_ADDR;
              bit_d   = 3'd7;
            end
            ST_ADDR: begin
              if (bit_q == 3'd0) begin
                state_d = ST_ACK1;
              end else begin
                bit_d   = bit_q - 3'd1;
                shift_d = {shift_q[6:0], 1'b0};
              end
            end
            ST_ACK1: begin
              if (nack_q) begin
                state_d = ST_STOP;
              end else begin
                state_d = ST_DATA;
                shift_d = data_q;
                bit_d   = 3'd7;
              end
            end
            ST_DATA: begin
              if (bit_q == 3'd0) begin
                state_d = ST_ACK2;
              end else begin
                bit_d   = bit_q - 3'd1;
                shift_d = {shift_q[6:0], 1'b0};
              end
            end
            ST_ACK2: state_d = ST_STOP;
            ST_STOP: state_d = ST_DONE;
            default: state_d = ST_IDLE;
          endcase
        end else begin
          state_d = state_q;
        end
      end
    endcase

    if (arb_en && (req != 2'b00)) begin
      busy_d = 1'b1;
      case (req)
        2'b01:   grant_d = 2'b01;
        2'b10:   grant_d = 2'b10;
        default: begin
          grant_d = rr_q ? 2'b10 : 2'b01;
          rr_d    = ~rr_q;
        end
      endcase
    end else begin
      grant_d = 2'b00;
    end

    done_d = (state_d == ST_DONE);
    // Bus pins are decoded from next-state values so the registered pins line up with the FSM.
    {scl_oe_d, sda_oe_d} = bus_drive(state_d, quarter_d, shift_d[7]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      quarter_q <= 2'd0;
      bit_q     <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      rr_q      <= 1'b0;
      grant_q   <= 2'b00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      nack_q    <= 1'b0;
      scl_oe_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      quarter_q <= quarter_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      rr_q      <= rr_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      nack_q    <= nack_d;
      scl_oe_q  <= scl_oe_d;
      sda_oe_q  <= sda_oe_d;
    end
  end

  assign grant  = grant_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign nack   = nack_q;
  assign scl_oe = scl_oe_q;
  assign sda_oe = sda_oe_q;

endmodule

// File: tb/tb_i2c_write_scheduler.sv
// Directed bench: two scheduler instances (CLK_DIV=4 and CLK_DIV=1) with a bus
// monitor that decodes bits on SCL rises and counts START/STOP edges.
module tb_i2c_write_scheduler;

  typedef struct {
    int         dut;
    logic [1:0] req;
    logic [6:0] a0;
    logic [6:0] a1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       na;
    logic       nd;
    logic [1:0] g;
    logic [7:0] b1;
    logic [7:0] b2;
    logic       nk;
    int         len;
    int         rises;
  } vec_t;

  logic       clk;
  logic       reset_v [2];
  logic [1:0] req_v [2];
  logic [6:0] addr0, addr1;
  logic [7:0] data0, data1;
  logic       sda_i_v [2];
  logic [1:0] grant_v [2];
  logic       busy_v [2], done_v [2], nack_v [2], scl_oe_v [2], sda_oe_v [2];
  logic       nack_addr, nack_data;

  int         cyc = 0;
  int         n_chk = 0;
  int         n_err = 0;
  int         rise_cnt [2];
  int         start_cnt [2];
  int         stop_cnt [2];
  int         done_cnt [2];
  logic [7:0] byte1 [2];
  logic [7:0] byte2 [2];
  logic       prev_scl [2];
  logic       prev_sda [2];
  vec_t       vecs [6];

  i2c_write_scheduler #(.CLK_DIV(4)) u_dut0 (
    .clk(clk), .reset(reset_v[0]), .req(req_v[0]),
    .addr0(addr0), .addr1(addr1), .data0(data0), .data1(data1),
    .sda_i(sda_i_v[0]), .grant(grant_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .nack(nack_v[0]), .scl_oe(scl_oe_v[0]), .sda_oe(sda_oe_v[0])
  );

  i2c_write_scheduler #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .reset(reset_v[1]), .req(req_v[1]),
    .addr0(addr0), .addr1(addr1), .data0(data0), .data1(data1),
    .sda_i(sda_i_v[1]), .grant(grant_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .nack(nack_v[1]), .scl_oe(scl_oe_v[1]), .sda_oe(sda_oe_v[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Open-drain slave model: pulls SDA low around the ACK rises unless told to NACK.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      sda_i_v[i] = ~sda_oe_v[i] &
                   ~((((rise_cnt[i] == 8) || (rise_cnt[i] == 9)) && !nack_addr) ||
                     (((rise_cnt[i] == 17) || (rise_cnt[i] == 18)) && !nack_data));
    end
  end

  task automatic monitor_step();
    for (int i = 0; i < 2; i++) begin
      if (grant_v[i] != 2'b00) begin
        rise_cnt[i] = 0; start_cnt[i] = 0; stop_cnt[i] = 0;
        byte1[i] = 8'h00; byte2[i] = 8'h00;
      end
      if (prev_scl[i] && !scl_oe_v[i]) begin
        rise_cnt[i] = rise_cnt[i] + 1;
        if (rise_cnt[i] >= 1 && rise_cnt[i] <= 8) byte1[i] = {byte1[i][6:0], ~sda_oe_v[i]};
        else if (rise_cnt[i] >= 10 && rise_cnt[i] <= 17) byte2[i] = {byte2[i][6:0], ~sda_oe_v[i]};
      end
      if (!prev_scl[i] && !scl_oe_v[i] && (prev_sda[i] != sda_oe_v[i])) begin
        if (sda_oe_v[i]) start_cnt[i] = start_cnt[i] + 1;
        else stop_cnt[i] = stop_cnt[i] + 1;
      end
      if (done_v[i]) done_cnt[i] = done_cnt[i] + 1;
      prev_scl[i] = scl_oe_v[i];
      prev_sda[i] = sda_oe_v[i];
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rise_cnt[i] = 0; start_cnt[i] = 0; stop_cnt[i] = 0; done_cnt[i] = 0;
      byte1[i] = 8'h00; byte2[i] = 8'h00; prev_scl[i] = 1'b0; prev_sda[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      monitor_step();
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_grant(input int d, input int lim, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clk);
      if (grant_v[d] != 2'b00) ok = 1'b1;
    end
  endtask

  task automatic wait_done(input int d, input int lim, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clk);
      if (done_v[d]) ok = 1'b1;
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic ok;
    int   tg;
    int   d;
    d = v.dut;
    addr0 = v.a0; addr1 = v.a1; data0 = v.d0; data1 = v.d1;
    nack_addr = v.na; nack_data = v.nd;
    req_v[d] = v.req;
    wait_grant(d, 20, ok);
    check($sformatf("v%0d_grant", idx), 32'(grant_v[d]), 32'(v.g));
    tg = cyc;
    req_v[d] = req_v[d] & ~grant_v[d];
    wait_done(d, 400, ok);
    check($sformatf("v%0d_len", idx), 32'(cyc - tg), 32'(v.len));
    check($sformatf("v%0d_nack", idx), 32'(nack_v[d]), 32'(v.nk));
    check($sformatf("v%0d_byte1", idx), 32'(byte1[d]), 32'(v.b1));
    check($sformatf("v%0d_byte2", idx), 32'(byte2[d]), 32'(v.b2));
    check($sformatf("v%0d_rises", idx), 32'(rise_cnt[d]), 32'(v.rises));
    check($sformatf("v%0d_start", idx), 32'(start_cnt[d]), 32'd1);
    check($sformatf("v%0d_stop", idx), 32'(stop_cnt[d]), 32'd1);
    check($sformatf("v%0d_busy_done", idx), 32'(busy_v[d]), 32'd1);
    @(negedge clk);
    check($sformatf("v%0d_busy_after", idx), 32'(busy_v[d]), 32'd0);
  endtask

  initial begin
    logic ok;
    int   last_done;
    int   dc;
    logic [1:0] rr_exp [4];

    vecs[0] = '{0, 2'b01, 7'h50, 7'h00, 8'hA5, 8'h00, 1'b0, 1'b0, 2'b01, 8'hA0, 8'hA5, 1'b0, 321, 19};
    vecs[1] = '{0, 2'b10, 7'h00, 7'h3C, 8'h00, 8'h0F, 1'b0, 1'b0, 2'b10, 8'h78, 8'h0F, 1'b0, 321, 19};
    vecs[2] = '{0, 2'b01, 7'h7F, 7'h00, 8'h00, 8'h00, 1'b1, 1'b0, 2'b01, 8'hFE, 8'h00, 1'b1, 177, 10};
    vecs[3] = '{0, 2'b10, 7'h00, 7'h01, 8'h00, 8'hFF, 1'b0, 1'b1, 2'b10, 8'h02, 8'hFF, 1'b1, 321, 19};
    vecs[4] = '{1, 2'b01, 7'h50, 7'h00, 8'hA5, 8'h00, 1'b0, 1'b0, 2'b01, 8'hA0, 8'hA5, 1'b0, 81, 19};
    vecs[5] = '{1, 2'b10, 7'h00, 7'h2A, 8'h00, 8'h5A, 1'b1, 1'b0, 2'b10, 8'h54, 8'h00, 1'b1, 45, 10};
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;

    for (int i = 0; i < 2; i++) begin
      reset_v[i] = 1'b1; req_v[i] = 2'b00;
    end
    addr0 = 7'h50; addr1 = 7'h3C; data0 = 8'hA5; data1 = 8'h0F;
    nack_addr = 1'b0; nack_data = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst%0d_grant", i), 32'(grant_v[i]), 32'd0);
      check($sformatf("rst%0d_busy", i), 32'(busy_v[i]), 32'd0);
      check($sformatf("rst%0d_done", i), 32'(done_v[i]), 32'd0);
      check($sformatf("rst%0d_nack", i), 32'(nack_v[i]), 32'd0);
      check($sformatf("rst%0d_scl", i), 32'(scl_oe_v[i]), 32'd0);
      check($sformatf("rst%0d_sda", i), 32'(sda_oe_v[i]), 32'd0);
      reset_v[i] = 1'b0;
    end
    @(negedge clk);

    // Round-robin with both requests held: grants alternate, each right after done.
    req_v[0] = 2'b11;
    last_done = -1;
    for (int k = 0; k < 4; k++) begin
      wait_grant(0, 400, ok);
      check($sformatf("rr%0d_grant", k), 32'(grant_v[0]), 32'(rr_exp[k]));
      if (k > 0) check($sformatf("rr%0d_spacing", k), 32'(cyc - last_done), 32'd1);
      if (k == 3) req_v[0] = 2'b00;
      wait_done(0, 400, ok);
      check($sformatf("rr%0d_done", k), 32'(ok), 32'd1);
      check($sformatf("rr%0d_byte1", k), 32'(byte1[0]), (k % 2 == 0) ? 32'hA0 : 32'h78);
      last_done = cyc;
    end
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Reset in the middle of DATA, then a contended request must go to requester 0.
    addr0 = 7'h50; addr1 = 7'h3C; data0 = 8'hA5; data1 = 8'h0F;
    nack_addr = 1'b0; nack_data = 1'b0;
    req_v[0] = 2'b11;
    wait_grant(0, 20, ok);
    check("mid_grant", 32'(grant_v[0]), 32'h1);
    req_v[0] = 2'b00;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (rise_cnt[0] >= 12) ok = 1'b1;
    end
    check("mid_reach_data", 32'(ok), 32'd1);
    reset_v[0] = 1'b1;
    dc = done_cnt[0];
    @(negedge clk);
    check("mid_scl", 32'(scl_oe_v[0]), 32'd0);
    check("mid_sda", 32'(sda_oe_v[0]), 32'd0);
    check("mid_busy", 32'(busy_v[0]), 32'd0);
    check("mid_done", 32'(done_v[0]), 32'd0);
    reset_v[0] = 1'b0;
    repeat (400) @(negedge clk);
    check("mid_no_done", 32'(done_cnt[0] - dc), 32'd0);
    req_v[0] = 2'b11;
    wait_grant(0, 20, ok);
    check("post_rst_grant", 32'(grant_v[0]), 32'h1);
    req_v[0] = 2'b00;
    wait_done(0, 400, ok);
    check("post_rst_done", 32'(ok), 32'd1);
    check("post_rst_byte1", 32'(byte1[0]), 32'hA0);
    check("post_rst_byte2", 32'(byte2[0]), 32'hA5);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
